// File: rtl/t05_spi_pkg.sv
// t05_spi_pkg: controller state codes and SPI FSM state type shared by the SPI writer
package t05_spi_pkg;
    localparam logic [3:0] ST_CBS = 4'd5;
    localparam logic [3:0] ST_TRN = 4'd6;
    localparam logic [3:0] ST_SPI = 4'd7;
    typedef enum logic {S_IDLE, S_SHIFT} spi_state_t;
endpackage

// File: rtl/t05_spi_if.sv
// t05_spi_if: bit-stream inputs and SPI/status outputs of the SPI writer
//   en_state, write_bit/en_hs, write_bit/en_tl : pipeline -> writer
//   bit_ready, mosi, sclk, cs_n, overflow, fin_spi (+ drop_cnt with T05_SPI_DROP_CNT_EN) : writer -> outside
interface t05_spi_if;
    logic [3:0] en_state;
    logic       write_bit_hs, write_en_hs, write_bit_tl, write_en_tl;
    logic       bit_ready, mosi, sclk, cs_n, overflow, fin_spi;
`ifdef T05_SPI_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif
    modport master (
        output en_state, write_bit_hs, write_en_hs, write_bit_tl, write_en_tl,
        input  bit_ready, mosi, sclk, cs_n, overflow, fin_spi
`ifdef T05_SPI_DROP_CNT_EN
        , drop_cnt
`endif
    );
    modport slave (
        input  en_state, write_bit_hs, write_en_hs, write_bit_tl, write_en_tl,
        output bit_ready, mosi, sclk, cs_n, overflow, fin_spi
`ifdef T05_SPI_DROP_CNT_EN
        , drop_cnt
`endif
    );
endinterface

// File: rtl/t05_spi_writer_fifo.sv
// t05_byte_fifo: small FIFO; push+pop together is legal even when full
//   push/din in, pop in, dout = head entry, full/empty flags
module t05_byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic do_push, do_pop;
    // extra MSB on the pointers tells full from empty when the indices match
    always_comb begin
        empty   = wr_q == rd_q;
        full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_d    = wr_q + {{AW{1'b0}}, do_push};
        rd_d    = rd_q + {{AW{1'b0}}, do_pop};
        dout    = mem[rd_q[AW-1:0]];
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    always_ff @(posedge clk)
        if (do_push) mem[wr_q[AW-1:0]] <= din;
endmodule

// File: rtl/t05_spi_writer.sv
// t05_spi_writer: packs hs/tl bit streams MSB-first into bytes and sends them over a mode-0 SPI master
//   clk, rst (async, active high); bus = t05_spi_if.slave
//   optional T05_SPI_DROP_CNT_EN adds a saturating drop counter driving overflow
module t05_spi_writer
    import t05_spi_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_DIV    = 2
) (
    input logic      clk,
    input logic      rst,
    t05_spi_if.slave bus
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    spi_state_t    state_q, state_d;
    logic [7:0]    acc_q, acc_d, shreg_q, shreg_d, fifo_din, fifo_dout;
    logic [2:0]    cnt_q, cnt_d, bit_cnt_q, bit_cnt_d;
    logic [DW-1:0] div_q, div_d;
    logic sclk_q, sclk_d, cs_n_q, cs_n_d, mosi_q, mosi_d, fin_q, fin_d;
    logic src_en, src_bit, ready, accept, drop, flush, push, pop, full, empty;

    t05_byte_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .din(fifo_din),
        .dout(fifo_dout), .full(full), .empty(empty)
    );

    always_comb begin
        src_en  = bus.en_state == ST_CBS ? bus.write_en_hs : bus.en_state == ST_TRN ? bus.write_en_tl : 1'b0;
        src_bit = bus.en_state == ST_CBS ? bus.write_bit_hs : bus.write_bit_tl;
        ready   = !(full && cnt_q == 3'd7);
        accept  = src_en && ready;
        drop    = src_en && !ready;
        // ST_SPI selects no source, so a flush never coincides with an accepted bit
        flush   = bus.en_state == ST_SPI && cnt_q != 3'd0 && !full;
        acc_d   = accept ? {acc_q[6:0], src_bit} : acc_q;
        cnt_d   = flush ? 3'd0 : accept ? cnt_q + 3'd1 : cnt_q;
        push    = flush || (accept && cnt_q == 3'd7);
        fifo_din = flush ? acc_q << (4'd8 - {1'b0, cnt_q}) : acc_d;
        fin_d   = bus.en_state == ST_SPI && cnt_q == 3'd0 && empty && state_q == S_IDLE;
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_d     = div_q;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        mosi_d    = mosi_q;
        pop       = 1'b0;
        if (state_q == S_IDLE) begin
            if (!empty) begin
                pop       = 1'b1;
                shreg_d   = fifo_dout;
                mosi_d    = fifo_dout[7];
                cs_n_d    = 1'b0;
                div_d     = '0;
                bit_cnt_d = 3'd0;
                state_d   = S_SHIFT;
            end
        end else if (div_q != DW'(CLK_DIV - 1)) begin
            div_d = div_q + DW'(1);
        end else begin
            div_d  = '0;
            sclk_d = !sclk_q;
            // sclk currently high: this toggle is the falling edge where mosi advances
            if (sclk_q) begin
                if (bit_cnt_q != 3'd7) begin
                    shreg_d   = {shreg_q[6:0], 1'b0};
                    mosi_d    = shreg_q[6];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end else if (!empty) begin
                    pop       = 1'b1;
                    shreg_d   = fifo_dout;
                    mosi_d    = fifo_dout[7];
                    bit_cnt_d = 3'd0;
                end else begin
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= 8'd0;
            cnt_q     <= 3'd0;
            shreg_q   <= 8'd0;
            bit_cnt_q <= 3'd0;
            div_q     <= '0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
            fin_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            div_q     <= div_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
            mosi_q    <= mosi_d;
            fin_q     <= fin_d;
        end

`ifdef T05_SPI_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;
    always_comb drop_cnt_d = (drop && drop_cnt_q != 8'hff) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) drop_cnt_q <= 8'd0;
        else     drop_cnt_q <= drop_cnt_d;
    assign bus.drop_cnt = drop_cnt_q;
    assign bus.overflow = drop_cnt_q != 8'd0;
`else
    logic ovf_q, ovf_d;
    always_comb ovf_d = ovf_q || drop;
    always_ff @(posedge clk or posedge rst)
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    assign bus.overflow = ovf_q;
`endif

    assign bus.bit_ready = ready;
    assign bus.mosi      = mosi_q;
    assign bus.sclk      = sclk_q;
    assign bus.cs_n      = cs_n_q;
    assign bus.fin_spi   = fin_q;
endmodule

// File: tb/tb_t05_spi_writer.sv
// tb_t05_spi_writer: randomized self-checking bench with a byte-level reference model
module tb_t05_spi_writer;
    import t05_spi_pkg::*;
    localparam int FD = 4, CD = 2, BYTE_CYC = 16 * CD;
    logic clk, rst;
    int checks = 0, failures = 0;
    t05_spi_if bus();
    t05_spi_writer #(.FIFO_DEPTH(FD), .CLK_DIV(CD)) dut (.clk(clk), .rst(rst), .bus(bus));
    logic f_push, f_pop, f_full, f_empty;
    logic [7:0] f_din, f_dout;
    t05_byte_fifo #(.WIDTH(8), .DEPTH(FD)) u_fifo (
        .clk(clk), .rst(rst), .push(f_push), .pop(f_pop), .din(f_din),
        .dout(f_dout), .full(f_full), .empty(f_empty)
    );
    logic [7:0] rx_q[$];
    int cs_runs[$];
    bit stim_q[$], exp_bits[$];
    int m_c, m_free, m_fcnt, m_cnt, m_drops;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete (got timeout, required finish)");
        $fatal(1);
    end

    // SPI slave: sample mosi on each sclk rise while selected, record chip-select low lengths
    initial begin
        int mon_n, cs_run;
        logic [7:0] mon_byte;
        logic sclk_prev, mosi_prev;
        mon_n = 0; cs_run = 0; mon_byte = 0; sclk_prev = 0; mosi_prev = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_n = 0;
                cs_run = 0;
            end else if (bus.cs_n === 1'b0) begin
                cs_run++;
                if (bus.sclk && !sclk_prev) begin
                    checks++;
                    if (bus.mosi !== mosi_prev) begin
                        failures++;
                        $display("FAIL mosi_stable: got %b at sclk rise, required %b", bus.mosi, mosi_prev);
                    end
                    mon_byte = {mon_byte[6:0], bus.mosi};
                    mon_n++;
                    if (mon_n == 8) begin
                        rx_q.push_back(mon_byte);
                        mon_n = 0;
                    end
                end
            end else begin
                mon_n = 0;
                if (cs_run != 0) cs_runs.push_back(cs_run);
                cs_run = 0;
            end
            sclk_prev = bus.sclk;
            mosi_prev = bus.mosi;
        end
    end

    task automatic fresh();
        m_c = 0; m_free = 0; m_fcnt = 0; m_cnt = 0;
        exp_bits.delete();
        rx_q.delete();
        cs_runs.delete();
        stim_q.delete();
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int j = 7; j >= 0; j--) stim_q.push_back(b[j]);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.en_state = 4'd0;
        bus.write_en_hs = 0;
        bus.write_en_tl = 0;
        repeat (n) @(negedge clk);
    endtask

    // Drive ncyc cycles; the selected source carries stim_q bits, the other pair carries junk.
    // Model: FIFO occupancy plus an SPI engine that takes one byte per BYTE_CYC cycles.
    task automatic drive(input logic [3:0] st, input int ncyc, input int pct);
        for (int i = 0; i < ncyc; i++) begin
            bit v, b, sel, ready, push, pop;
            @(negedge clk);
            v = stim_q.size() != 0 && $urandom_range(99) < pct;
            b = v ? stim_q.pop_front() : bit'($urandom_range(1));
            sel = st == ST_CBS || st == ST_TRN;
            bus.en_state     = st;
            bus.write_en_hs  = st == ST_CBS ? v : bit'($urandom_range(1));
            bus.write_bit_hs = st == ST_CBS ? b : bit'($urandom_range(1));
            bus.write_en_tl  = st == ST_TRN ? v : bit'($urandom_range(1));
            bus.write_bit_tl = st == ST_TRN ? b : bit'($urandom_range(1));
            ready = !(m_fcnt == FD && m_cnt == 7);
            checks++;
            if (bus.bit_ready !== ready) begin
                failures++;
                $display("FAIL bit_ready: cycle %0d got %b required %b", m_c, bus.bit_ready, ready);
            end
            push = 0;
            if (v && sel) begin
                if (ready) begin
                    exp_bits.push_back(b);
                    push = m_cnt == 7;
                    m_cnt = (m_cnt + 1) % 8;
                end else m_drops++;
            end
            pop = m_c >= m_free && m_fcnt > 0;
            if (pop) m_free = m_c + BYTE_CYC;
            m_fcnt += int'(push) - int'(pop);
            m_c++;
        end
    endtask

    task automatic finish_check(input string name);
        int t;
        logic [7:0] exp_q[$];
        logic [7:0] by;
        @(negedge clk);
        bus.en_state = ST_SPI;
        bus.write_en_hs = 0;
        bus.write_en_tl = 0;
        t = 0;
        while (t < 4000) begin
            @(negedge clk);
            t++;
            checks++;
            if (bus.fin_spi === 1'b1 && bus.cs_n !== 1'b1) begin
                failures++;
                $display("FAIL %s fin_early: fin_spi=1 with cs_n=%b, required cs_n=1", name, bus.cs_n);
            end
            if (bus.fin_spi === 1'b1) break;
        end
        checks++;
        if (bus.fin_spi !== 1'b1) begin
            failures++;
            $display("FAIL %s fin_timeout: fin_spi=%b, required 1", name, bus.fin_spi);
        end
        while (exp_bits.size() % 8 != 0) exp_bits.push_back(1'b0);
        for (int i = 0; i < exp_bits.size(); i += 8) begin
            for (int j = 0; j < 8; j++) by[7 - j] = exp_bits[i + j];
            exp_q.push_back(by);
        end
        checks++;
        if (rx_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s byte_count: got %0d required %0d", name, rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL %s byte[%0d]: got %h required %h", name, i, rx_q[i], exp_q[i]);
            end
        end
        checks++;
        if (bus.overflow !== (m_drops != 0)) begin
            failures++;
            $display("FAIL %s overflow: got %b required %b", name, bus.overflow, m_drops != 0);
        end
`ifdef T05_SPI_DROP_CNT_EN
        checks++;
        if (bus.drop_cnt !== 8'(m_drops > 255 ? 255 : m_drops)) begin
            failures++;
            $display("FAIL %s drop_cnt: got %0d required %0d", name, bus.drop_cnt, m_drops > 255 ? 255 : m_drops);
        end
`endif
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.fin_spi !== 1'b1) begin
                failures++;
                $display("FAIL %s fin_hold: got %b required 1", name, bus.fin_spi);
            end
        end
        bus.en_state = 4'd0;
        @(negedge clk);
        checks++;
        if (bus.fin_spi !== 1'b0) begin
            failures++;
            $display("FAIL %s fin_drop: got %b required 0", name, bus.fin_spi);
        end
    endtask

    task automatic check_runs(input string name, input int n, input int len);
        checks++;
        if (cs_runs.size() != n || (n != 0 && cs_runs[0] != len)) begin
            failures++;
            $display("FAIL %s cs_low: got %0d frames (first %0d cycles), required %0d of %0d", name,
                     cs_runs.size(), cs_runs.size() ? cs_runs[0] : 0, n, len);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        bus.en_state = 0; bus.write_en_hs = 0; bus.write_bit_hs = 0; bus.write_en_tl = 0; bus.write_bit_tl = 0;
        f_push = 0; f_pop = 0; f_din = 0;
        m_drops = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.mosi, bus.sclk, bus.cs_n, bus.bit_ready, bus.overflow, bus.fin_spi} !== 6'b001100) begin
            failures++;
            $display("FAIL reset_values: got mosi/sclk/cs_n/rdy/ovf/fin=%b required 001100",
                     {bus.mosi, bus.sclk, bus.cs_n, bus.bit_ready, bus.overflow, bus.fin_spi});
        end
        rst = 0;
        fresh();
        push_byte(8'(($urandom_range(255))));
        drive(ST_TRN, 8, 100);
        idle(20);
        checks++;
        if (bus.cs_n !== 1'b0) begin
            failures++;
            $display("FAIL reset_prep: cs_n got %b required 0 mid-byte", bus.cs_n);
        end
        #2 rst = 1;
        #1;
        checks++;
        if ({bus.mosi, bus.sclk, bus.cs_n, bus.bit_ready, bus.overflow, bus.fin_spi} !== 6'b001100) begin
            failures++;
            $display("FAIL reset_async: got mosi/sclk/cs_n/rdy/ovf/fin=%b required 001100",
                     {bus.mosi, bus.sclk, bus.cs_n, bus.bit_ready, bus.overflow, bus.fin_spi});
        end
        @(negedge clk);
        rst = 0;
        fresh();
        idle(80);
        checks++;
        if (rx_q.size() != 0 || cs_runs.size() != 0 || bus.cs_n !== 1'b1) begin
            failures++;
            $display("FAIL reset_stale: got %0d bytes, %0d frames, cs_n=%b; required 0, 0, 1",
                     rx_q.size(), cs_runs.size(), bus.cs_n);
        end
    endtask

    task automatic test_cbs_frame();
        logic [7:0] b = 8'b1011_0010;
        fresh();
        push_byte(b);
        drive(ST_CBS, 8, 100);
        finish_check("cbs");
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'hB2) begin
            failures++;
            $display("FAIL cbs_byte: got %0d bytes first %h required 1 byte B2", rx_q.size(), rx_q.size() ? rx_q[0] : 8'h0);
        end
        check_runs("cbs", 1, BYTE_CYC);
    endtask

    task automatic test_back_to_back();
        fresh();
        drive(ST_CBS, 16, 100);
        push_byte(8'hA5);
        push_byte(8'h3C);
        push_byte(8'hFF);
        drive(ST_TRN, 24, 100);
        finish_check("trn3");
        checks++;
        if (rx_q.size() != 3 || rx_q[0] !== 8'hA5 || rx_q[1] !== 8'h3C || rx_q[2] !== 8'hFF) begin
            failures++;
            $display("FAIL trn3_bytes: got %0d bytes, required A5 3C FF", rx_q.size());
        end
        check_runs("trn3", 1, 3 * BYTE_CYC);
    endtask

    task automatic test_flush();
        fresh();
        stim_q = '{1'b1, 1'b1, 1'b0};
        drive(ST_TRN, 3, 100);
        finish_check("flush");
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'hC0) begin
            failures++;
            $display("FAIL flush_byte: got %0d bytes first %h required 1 byte C0", rx_q.size(), rx_q.size() ? rx_q[0] : 8'h0);
        end
        check_runs("flush", 1, BYTE_CYC);
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            fresh();
            repeat ($urandom_range(80, 30)) stim_q.push_back(bit'($urandom_range(1)));
            for (int s = 0; s < 3; s++) begin
                int r = $urandom_range(2);
                drive(r == 0 ? ST_CBS : r == 1 ? ST_TRN : 4'd2, $urandom_range(60, 20), $urandom_range(90, 20));
            end
            finish_check("random");
        end
    endtask

    task automatic test_overflow();
        fresh();
        repeat (64) stim_q.push_back(bit'($urandom_range(1)));
        drive(ST_TRN, 64, 100);
        checks++;
        if (bus.overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_set: got %b required 1", bus.overflow);
        end
        finish_check("overflow");
    endtask

    task automatic test_fifo_same_cycle();
        logic [7:0] q[$];
        for (int i = 0; i < FD; i++) begin
            @(negedge clk);
            f_push = 1; f_pop = 0; f_din = 8'($urandom_range(255));
            q.push_back(f_din);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (f_full !== 1'b1) begin
                failures++;
                $display("FAIL fifo_full: got %b required 1", f_full);
            end
            checks++;
            if (f_dout !== q[0]) begin
                failures++;
                $display("FAIL fifo_pushpop_head: got %h required %h", f_dout, q[0]);
            end
            void'(q.pop_front());
            f_push = 1; f_pop = 1; f_din = 8'($urandom_range(255));
            q.push_back(f_din);
        end
        for (int i = 0; i < FD; i++) begin
            @(negedge clk);
            checks++;
            if (f_dout !== q[0]) begin
                failures++;
                $display("FAIL fifo_drain[%0d]: got %h required %h", i, f_dout, q[0]);
            end
            void'(q.pop_front());
            f_push = 0; f_pop = 1;
        end
        @(negedge clk);
        f_pop = 0;
        checks++;
        if (f_empty !== 1'b1) begin
            failures++;
            $display("FAIL fifo_empty: got %b required 1", f_empty);
        end
    endtask

    initial begin
        test_reset();
        test_cbs_frame();
        test_back_to_back();
        test_flush();
        test_random();
        test_overflow();
        test_fifo_same_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
